instr_sequencer: RTL and testbench

- Parametrised successor to the processor's control-state sequencer. It drives the control unit with a state code each clock.
- Adds over the previous generation:
  - async reset
  - configurable opcode/IR width
  - memory wait-state handshake
  - continuous-run vs single-step mode
  - HALT and illegal-opcode handling
  - SUB/INC/JUMP/JMPZ instruction flows
- Sits between IR/ALU flags and the control unit's state decoder.

---
 rtl/instr_seq_pkg.sv | 62 ++++++
 rtl/opcode_decoder.sv | 39 +++
 rtl/instr_sequencer.sv | 102 ++++++++++
 tb/tb_instr_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared state codes, opcode values and state classification helpers for the
// instruction sequencer. State codes are 5 bits; wider state buses zero-extend.
package instr_seq_pkg;

    localparam logic [4:0] S_IDLE     = 5'd0;
    localparam logic [4:0] S_FETCH1   = 5'd1;
    localparam logic [4:0] S_FETCH2   = 5'd2;
    localparam logic [4:0] S_FETCH3   = 5'd3;
    localparam logic [4:0] S_CLAC     = 5'd4;
    localparam logic [4:0] S_LDAC1    = 5'd5;
    localparam logic [4:0] S_LDAC2    = 5'd6;
    localparam logic [4:0] S_LDAC3    = 5'd7;
    localparam logic [4:0] S_LDAC4    = 5'd8;
    localparam logic [4:0] S_STAC1    = 5'd9;
    localparam logic [4:0] S_STAC2    = 5'd10;
    localparam logic [4:0] S_STAC3    = 5'd11;
    localparam logic [4:0] S_STAC4    = 5'd12;
    localparam logic [4:0] S_MVACR    = 5'd13;
    localparam logic [4:0] S_MVRAC    = 5'd14;
    localparam logic [4:0] S_ADD      = 5'd15;
    localparam logic [4:0] S_MUL      = 5'd16;
    localparam logic [4:0] S_SUB      = 5'd17;
    localparam logic [4:0] S_INC      = 5'd18;
    localparam logic [4:0] S_JUMP1    = 5'd19;
    localparam logic [4:0] S_JUMP2    = 5'd20;
    localparam logic [4:0] S_JMPZ_CHK = 5'd21;
    localparam logic [4:0] S_JMPZ_Y1  = 5'd22;
    localparam logic [4:0] S_JMPZ_Y2  = 5'd23;
    localparam logic [4:0] S_HALT     = 5'd24;
    localparam logic [4:0] S_ERR      = 5'd25;

    localparam logic [3:0] OP_HALT  = 4'd0;
    localparam logic [3:0] OP_CLAC  = 4'd1;
    localparam logic [3:0] OP_LDAC  = 4'd2;
    localparam logic [3:0] OP_STAC  = 4'd3;
    localparam logic [3:0] OP_MVACR = 4'd4;
    localparam logic [3:0] OP_MVRAC = 4'd5;
    localparam logic [3:0] OP_ADD   = 4'd6;
    localparam logic [3:0] OP_MUL   = 4'd7;
    localparam logic [3:0] OP_SUB   = 4'd8;
    localparam logic [3:0] OP_INC   = 4'd9;
    localparam logic [3:0] OP_JUMP  = 4'd10;
    localparam logic [3:0] OP_JMPZ  = 4'd11;

    function automatic logic is_mem_state(input logic [4:0] code);
        case (code)
            S_FETCH2, S_LDAC2, S_LDAC4, S_STAC3, S_JUMP1, S_JMPZ_Y1: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // jmpz_chk ends the instruction only when the jump is not taken.
    function automatic logic is_terminal(input logic [4:0] code, input logic z_flag);
        case (code)
            S_CLAC, S_LDAC4, S_STAC4, S_MVACR, S_MVRAC, S_ADD, S_MUL,
            S_SUB, S_INC, S_JUMP2, S_JMPZ_Y2: return 1'b1;
            S_JMPZ_CHK: return !z_flag;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Maps the opcode field to the first execute state; opcodes above JMPZ are
// reported illegal and steer to the error state.
module opcode_decoder
    import instr_seq_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [4:0]              first_state,
    output logic                    illegal
);

    always_comb begin
        first_state = S_ERR;
        illegal     = 1'b1;
        if (opcode <= OPCODE_WIDTH'(OP_JMPZ)) begin
            illegal = 1'b0;
            case (opcode[3:0])
                OP_HALT:  first_state = S_HALT;
                OP_CLAC:  first_state = S_CLAC;
                OP_LDAC:  first_state = S_LDAC1;
                OP_STAC:  first_state = S_STAC1;
                OP_MVACR: first_state = S_MVACR;
                OP_MVRAC: first_state = S_MVRAC;
                OP_ADD:   first_state = S_ADD;
                OP_MUL:   first_state = S_MUL;
                OP_SUB:   first_state = S_SUB;
                OP_INC:   first_state = S_INC;
                OP_JUMP:  first_state = S_JUMP1;
                OP_JMPZ:  first_state = S_JMPZ_CHK;
                default: begin
                    first_state = S_ERR;
                    illegal     = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Control-state sequencer: walks fetch/decode/execute states, stalls memory
// states on mem_ready, and traps into halt or err until reset.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int IR_WIDTH     = 16,
    parameter int OPCODE_WIDTH = 4,
    parameter int STATE_WIDTH  = 6,
    parameter int MEM_WAIT_EN  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   step_mode,
    input  logic [IR_WIDTH-1:0]    IR,
    input  logic                   z_flag,
    input  logic                   mem_ready,
    output logic [STATE_WIDTH-1:0] state,
    output logic                   instr_done,
    output logic                   halted,
    output logic                   illegal_op
);

    logic [STATE_WIDTH-1:0] r_state;
    logic                   r_halted;
    logic                   r_illegal;

    logic [4:0] w_code;
    logic       w_valid;
    logic       w_stall;
    logic [4:0] w_dec_state;
    logic       w_dec_illegal;
    logic [4:0] w_next;
    logic       w_done;
    logic       w_unused_ir;

    opcode_decoder #(
        .OPCODE_WIDTH(OPCODE_WIDTH)
    ) u_decoder (
        .opcode      (IR[OPCODE_WIDTH-1:0]),
        .first_state (w_dec_state),
        .illegal     (w_dec_illegal)
    );

    assign w_unused_ir = ^IR;
    assign w_code      = r_state[4:0];
    assign w_valid     = (r_state <= STATE_WIDTH'(S_ERR));
    assign w_stall     = (MEM_WAIT_EN != 0) && is_mem_state(w_code) && !mem_ready;

    // halt and err fall through to the default hold, so start has no effect there.
    always_comb begin
        w_next = w_code;
        w_done = 1'b0;
        if (!w_valid) begin
            w_next = S_ERR;
        end else if (start && !w_stall) begin
            if (is_terminal(w_code, z_flag)) begin
                w_next = step_mode ? S_IDLE : S_FETCH1;
                w_done = 1'b1;
            end else begin
                case (w_code)
                    S_IDLE:     w_next = S_FETCH1;
                    S_FETCH1:   w_next = S_FETCH2;
                    S_FETCH2:   w_next = S_FETCH3;
                    S_FETCH3:   w_next = w_dec_illegal ? S_ERR : w_dec_state;
                    S_LDAC1:    w_next = S_LDAC2;
                    S_LDAC2:    w_next = S_LDAC3;
                    S_LDAC3:    w_next = S_LDAC4;
                    S_STAC1:    w_next = S_STAC2;
                    S_STAC2:    w_next = S_STAC3;
                    S_STAC3:    w_next = S_STAC4;
                    S_JUMP1:    w_next = S_JUMP2;
                    S_JMPZ_CHK: w_next = S_JMPZ_Y1;
                    S_JMPZ_Y1:  w_next = S_JMPZ_Y2;
                    default:    w_next = w_code;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= STATE_WIDTH'(w_next);
            if (w_next == S_HALT) begin
                r_halted <= 1'b1;
            end
            if (w_next == S_ERR) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign state      = r_state;
    assign instr_done = w_done;
    assign halted     = r_halted;
    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: each scenario is a table of per-cycle inputs and
// expected outputs; expectations queue on drive and are checked one by one.
module tb_instr_sequencer;

    localparam int IR_W  = 16;
    localparam int ST_W  = 6;
    localparam int EXP_W = ST_W + 3;

    typedef struct packed {
        logic       rst;
        logic       s;
        logic       stp;
        logic       z;
        logic       mr;
        logic [3:0] op;
        logic [4:0] es;
        logic       ed;
        logic       eh;
        logic       ei;
    } row_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            step_mode = 1'b0;
    logic [IR_W-1:0] ir = '0;
    logic            z_flag = 1'b0;
    logic            mem_ready = 1'b1;
    logic [ST_W-1:0] state;
    logic            instr_done;
    logic            halted;
    logic            illegal_op;

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    instr_sequencer #(
        .IR_WIDTH(IR_W), .OPCODE_WIDTH(4), .STATE_WIDTH(ST_W), .MEM_WAIT_EN(1)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .step_mode(step_mode),
        .IR(ir), .z_flag(z_flag), .mem_ready(mem_ready),
        .state(state), .instr_done(instr_done), .halted(halted), .illegal_op(illegal_op)
    );

    function automatic row_t mk(input logic rst, input logic s, input logic stp, input logic z,
                                input logic mr, input logic [3:0] op, input logic [4:0] es,
                                input logic ed, input logic eh, input logic ei);
        row_t r;
        r = '{rst, s, stp, z, mr, op, es, ed, eh, ei};
        return r;
    endfunction

    function automatic logic [IR_W-1:0] make_ir(input logic [3:0] op);
        logic [IR_W-1:0] w;
        w = IR_W'($urandom_range(0, 65535));
        w[3:0] = op;
        return w;
    endfunction

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic apply(input row_t r);
        @(negedge clock);
        reset     = r.rst;
        start     = r.s;
        step_mode = r.stp;
        z_flag    = r.z;
        mem_ready = r.mr;
        ir        = make_ir(r.op);
        exp_q.push_back({ST_W'(r.es), r.ed, r.eh, r.ei});
        #1;
    endtask

    task automatic test_reset();
        row_t rows[2];
        logic [EXP_W-1:0] got, exp_v;
        rows = '{mk(1,1,0,0,1,6, 0,0,0,0), mk(1,1,0,0,1,6, 0,0,0,0)};
        for (int i = 0; i < 2; i++) begin
            apply(rows[i]);
            got = {state, instr_done, halted, illegal_op};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL reset[%0d]: got state=%0d done/halt/ill=%b, expected state=%0d done/halt/ill=%b", i, got[EXP_W-1:3], got[2:0], exp_v[EXP_W-1:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_add();
        row_t rows[10];
        logic [EXP_W-1:0] got, exp_v;
        rows = '{mk(0,1,0,0,1,6, 0,0,0,0), mk(0,1,0,0,1,6, 1,0,0,0), mk(0,1,0,0,1,6, 2,0,0,0),
                 mk(0,1,0,0,1,6, 3,0,0,0), mk(0,1,0,0,1,6,15,1,0,0), mk(0,1,0,0,1,6, 1,0,0,0),
                 mk(0,1,0,0,1,6, 2,0,0,0), mk(0,1,0,0,1,6, 3,0,0,0), mk(0,1,1,0,1,6,15,1,0,0),
                 mk(0,0,1,0,1,6, 0,0,0,0)};
        for (int i = 0; i < 10; i++) begin
            apply(rows[i]);
            got = {state, instr_done, halted, illegal_op};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL add[%0d]: got state=%0d done/halt/ill=%b, expected state=%0d done/halt/ill=%b", i, got[EXP_W-1:3], got[2:0], exp_v[EXP_W-1:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_ldac_wait();
        row_t rows[14];
        logic [EXP_W-1:0] got, exp_v;
        rows = '{mk(0,1,1,0,1,2, 0,0,0,0), mk(0,1,1,0,1,2, 1,0,0,0), mk(0,1,1,0,0,2, 2,0,0,0),
                 mk(0,1,1,0,1,2, 2,0,0,0), mk(0,1,1,0,1,2, 3,0,0,0), mk(0,1,1,0,1,2, 5,0,0,0),
                 mk(0,1,1,0,0,2, 6,0,0,0), mk(0,1,1,0,0,2, 6,0,0,0), mk(0,1,1,0,0,2, 6,0,0,0),
                 mk(0,1,1,0,1,2, 6,0,0,0), mk(0,1,1,0,1,2, 7,0,0,0), mk(0,1,1,0,0,2, 8,0,0,0),
                 mk(0,1,1,0,1,2, 8,1,0,0), mk(0,0,1,0,1,2, 0,0,0,0)};
        for (int i = 0; i < 14; i++) begin
            apply(rows[i]);
            got = {state, instr_done, halted, illegal_op};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL ldac_wait[%0d]: got state=%0d done/halt/ill=%b, expected state=%0d done/halt/ill=%b", i, got[EXP_W-1:3], got[2:0], exp_v[EXP_W-1:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_jmpz();
        row_t rows[16];
        logic [EXP_W-1:0] got, exp_v;
        rows = '{mk(0,1,0,1,1,11, 0,0,0,0), mk(0,1,0,1,1,11, 1,0,0,0), mk(0,1,0,1,1,11, 2,0,0,0),
                 mk(0,1,0,1,1,11, 3,0,0,0), mk(0,1,0,1,1,11,21,0,0,0), mk(0,1,0,1,1,11,22,0,0,0),
                 mk(0,1,0,1,1,11,23,1,0,0), mk(0,1,0,0,1,11, 1,0,0,0), mk(0,1,0,0,1,11, 2,0,0,0),
                 mk(0,1,0,0,1,11, 3,0,0,0), mk(0,1,0,0,1,11,21,1,0,0), mk(0,1,0,0,1, 1, 1,0,0,0),
                 mk(0,1,0,0,1, 1, 2,0,0,0), mk(0,1,0,0,1, 1, 3,0,0,0), mk(0,1,1,0,1, 1, 4,1,0,0),
                 mk(0,0,1,0,1, 1, 0,0,0,0)};
        for (int i = 0; i < 16; i++) begin
            apply(rows[i]);
            got = {state, instr_done, halted, illegal_op};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL jmpz[%0d]: got state=%0d done/halt/ill=%b, expected state=%0d done/halt/ill=%b", i, got[EXP_W-1:3], got[2:0], exp_v[EXP_W-1:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_pause();
        row_t rows[15];
        logic [EXP_W-1:0] got, exp_v;
        rows = '{mk(0,1,1,0,1,3, 0,0,0,0), mk(0,1,1,0,1,3, 1,0,0,0), mk(0,1,1,0,1,3, 2,0,0,0),
                 mk(0,1,1,0,1,3, 3,0,0,0), mk(0,1,1,0,1,3, 9,0,0,0), mk(0,0,1,0,1,3,10,0,0,0),
                 mk(0,0,1,0,0,3,10,0,0,0), mk(0,0,1,0,1,3,10,0,0,0), mk(0,0,1,0,0,3,10,0,0,0),
                 mk(0,0,1,0,1,3,10,0,0,0), mk(0,1,1,0,1,3,10,0,0,0), mk(0,1,1,0,1,3,11,0,0,0),
                 mk(0,0,1,0,1,3,12,0,0,0), mk(0,1,1,0,1,3,12,1,0,0), mk(0,0,1,0,1,3, 0,0,0,0)};
        for (int i = 0; i < 15; i++) begin
            apply(rows[i]);
            got = {state, instr_done, halted, illegal_op};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL pause[%0d]: got state=%0d done/halt/ill=%b, expected state=%0d done/halt/ill=%b", i, got[EXP_W-1:3], got[2:0], exp_v[EXP_W-1:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_halt();
        row_t rows[10];
        logic [EXP_W-1:0] got, exp_v;
        rows = '{mk(0,1,1,0,1,0, 0,0,0,0), mk(0,1,1,0,1,0, 1,0,0,0), mk(0,1,1,0,1,0, 2,0,0,0),
                 mk(0,1,1,0,1,0, 3,0,0,0), mk(0,1,1,0,1,0,24,0,1,0), mk(0,0,1,0,1,0,24,0,1,0),
                 mk(0,1,1,0,1,0,24,0,1,0), mk(0,0,0,1,0,0,24,0,1,0), mk(1,1,1,0,1,0, 0,0,0,0),
                 mk(0,0,1,0,1,0, 0,0,0,0)};
        for (int i = 0; i < 10; i++) begin
            apply(rows[i]);
            got = {state, instr_done, halted, illegal_op};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL halt[%0d]: got state=%0d done/halt/ill=%b, expected state=%0d done/halt/ill=%b", i, got[EXP_W-1:3], got[2:0], exp_v[EXP_W-1:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_illegal();
        row_t rows[16];
        logic [EXP_W-1:0] got, exp_v;
        logic [3:0] bad;
        bad = 4'($urandom_range(12, 15));
        rows = '{mk(0,1,1,0,1,13, 0,0,0,0), mk(0,1,1,0,1,13, 1,0,0,0), mk(0,1,1,0,1,13, 2,0,0,0),
                 mk(0,1,1,0,1,13, 3,0,0,0), mk(0,1,1,0,1,13,25,0,0,1), mk(0,0,1,0,1,13,25,0,0,1),
                 mk(0,1,0,1,0, 6,25,0,0,1), mk(1,1,1,0,1,13, 0,0,0,0), mk(0,0,1,0,1,13, 0,0,0,0),
                 mk(0,1,0,0,1,bad, 0,0,0,0), mk(0,1,0,0,1,bad, 1,0,0,0), mk(0,1,0,0,1,bad, 2,0,0,0),
                 mk(0,1,0,0,1,bad, 3,0,0,0), mk(0,1,0,0,1,bad,25,0,0,1), mk(1,1,0,0,1,bad, 0,0,0,0),
                 mk(0,0,1,0,1,bad, 0,0,0,0)};
        for (int i = 0; i < 16; i++) begin
            apply(rows[i]);
            got = {state, instr_done, halted, illegal_op};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL illegal[%0d]: got state=%0d done/halt/ill=%b, expected state=%0d done/halt/ill=%b", i, got[EXP_W-1:3], got[2:0], exp_v[EXP_W-1:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        row_t rows[12];
        logic [EXP_W-1:0] got, exp_v;
        rows = '{mk(0,1,1,0,1,2, 0,0,0,0), mk(0,1,1,0,1,2, 1,0,0,0), mk(0,1,1,0,1,2, 2,0,0,0),
                 mk(0,1,1,0,1,2, 3,0,0,0), mk(0,1,1,0,1,2, 5,0,0,0), mk(0,1,1,0,0,2, 6,0,0,0),
                 mk(0,1,1,0,0,2, 6,0,0,0), mk(1,1,1,0,0,2, 0,0,0,0), mk(0,1,1,0,1,2, 0,0,0,0),
                 mk(0,1,1,0,1,2, 1,0,0,0), mk(0,1,1,0,1,2, 2,0,0,0), mk(0,0,1,0,1,2, 3,0,0,0)};
        for (int i = 0; i < 12; i++) begin
            apply(rows[i]);
            got = {state, instr_done, halted, illegal_op};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL reset_mid_stall[%0d]: got state=%0d done/halt/ill=%b, expected state=%0d done/halt/ill=%b", i, got[EXP_W-1:3], got[2:0], exp_v[EXP_W-1:3], exp_v[2:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldac_wait();
        test_jmpz();
        test_pause();
        test_halt();
        test_illegal();
        test_reset_mid_stall();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: got %0d leftover entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
